// File: rtl/psram_byte_bridge.sv
// -----------------------------------------------------------------------------
// psram_byte_bridge
//
// Byte-level front end for the PSRAM controller. Accepts byte reads (cart bus)
// and byte writes (ROM loader), serialises them into single-cycle strobes on
// the controller's word port, waits out mem_busy and returns the addressed
// byte. Reads win over writes. A watchdog aborts any access the controller
// never finishes.
//
// Optional feature: define PSRAM_BRIDGE_CACHE_EN to add a one-entry word cache
// (tag = addr[21:1]). Read hits complete without touching the PSRAM. Without
// the macro every read goes through ISSUE/WAIT.
//
// Parameters
//   TIMEOUT   max cycles spent in WAIT before the access is aborted
//   ERR_BYTE  byte returned on rd_data for a read that timed out
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   ready               a new request may be presented this cycle
//   rd_req/rd_addr      read request, sampled only while ready=1
//   rd_data/rd_valid    returned byte (held) and one-cycle completion pulse
//   wr_req/wr_addr/wr_data  write request, sampled only while ready=1
//   wr_ack              one-cycle write completion pulse
//   timeout_err         pulses with rd_valid/wr_ack when the access aborted
//   mem_read/mem_write  one-cycle strobes to the controller
//   mem_addr/mem_din    byte address and write word {wr_data, wr_data}
//   mem_byte_write      constant 1: every write is a byte write
//   mem_dout/mem_busy   last read word and busy flag from the controller
// -----------------------------------------------------------------------------
module psram_byte_bridge #(
  parameter int         TIMEOUT  = 4096,
  parameter logic [7:0] ERR_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic        rd_req,
  input  logic [21:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        wr_req,
  input  logic [21:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        timeout_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_byte_write,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } wr_req_t;

  state_t        state, state_nxt;
  logic          rd_pend, wr_pend;
  logic [21:0]   rd_addr_q;
  wr_req_t       wr_q;
  logic          op_rd;        // access in flight is a read
  logic [CW-1:0] wdog;

  logic          acc_rd, acc_wr;
  logic          start_rd, start_wr, done, abort;

  // cache hooks; tied off when the cache is not built
  logic          hit_now;      // rd_addr hits the cache this cycle
  logic [7:0]    hit_byte;
  logic          hit_pend;     // rd_pend is held only to cover a hit's pulse

  assign acc_rd = ready & rd_req;
  assign acc_wr = ready & wr_req;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_pend && !hit_pend) begin
          start_rd  = 1'b1;
          state_nxt = ISSUE;
        end else if (wr_pend) begin
          start_wr  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      // busy is not looked at here: the controller raises it on the next edge
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (!mem_busy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wdog == CW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // reset gates ready so nothing is accepted while the controller is held
    ready          = !reset && (state == IDLE) && !mem_busy && !rd_pend && !wr_pend;
    mem_read       = (state == ISSUE) &&  op_rd;
    mem_write      = (state == ISSUE) && !op_rd;
    mem_din        = {wr_q.data, wr_q.data};
    mem_byte_write = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Request capture, access tracking, completion pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      rd_addr_q   <= '0;
      wr_q        <= '0;
      op_rd       <= 1'b0;
      wdog        <= '0;
      mem_addr    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      wr_ack      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rd_valid    <= 1'b0;
      wr_ack      <= 1'b0;
      timeout_err <= 1'b0;

      if (acc_rd) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= rd_addr;
        // a cache hit answers straight away; rd_pend stays up one more
        // cycle so ready does not return alongside rd_valid
        if (hit_now) begin
          rd_valid <= 1'b1;
          rd_data  <= hit_byte;
        end
      end
      if (acc_wr) begin
        wr_pend   <= 1'b1;
        wr_q.addr <= wr_addr;
        wr_q.data <= wr_data;
      end

      if (state == IDLE && hit_pend) rd_pend <= 1'b0;

      if (start_rd) begin
        op_rd    <= 1'b1;
        mem_addr <= rd_addr_q;
      end
      if (start_wr) begin
        op_rd    <= 1'b0;
        mem_addr <= wr_q.addr;
      end

      if (state == ISSUE)     wdog <= '0;
      else if (state == WAIT) wdog <= wdog + CW'(1);

      if (done || abort) begin
        timeout_err <= abort;
        if (op_rd) begin
          rd_valid <= 1'b1;
          rd_pend  <= 1'b0;
          if (abort)             rd_data <= ERR_BYTE;
          else if (rd_addr_q[0]) rd_data <= mem_dout[15:8];
          else                   rd_data <= mem_dout[7:0];
        end else begin
          wr_ack  <= 1'b1;
          wr_pend <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional one-entry word cache
  // ---------------------------------------------------------------------------
`ifdef PSRAM_BRIDGE_CACHE_EN
  logic        c_vld;
  logic [20:0] c_tag;
  logic [15:0] c_word;

  assign hit_now  = c_vld && (c_tag == rd_addr[21:1]);
  assign hit_byte = rd_addr[0] ? c_word[15:8] : c_word[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_vld    <= 1'b0;
      c_tag    <= '0;
      c_word   <= '0;
      hit_pend <= 1'b0;
    end else begin
      if (acc_rd && hit_now)  hit_pend <= 1'b1;
      else if (state == IDLE) hit_pend <= 1'b0;

      // every completed miss refills; a timed-out read leaves nothing trustworthy
      if (op_rd && done) begin
        c_vld  <= 1'b1;
        c_tag  <= rd_addr_q[21:1];
        c_word <= mem_dout;
      end else if (op_rd && abort) begin
        c_vld  <= 1'b0;
      end

      // keep the cached word coherent with writes going out to the PSRAM
      if (start_wr && c_vld && (c_tag == wr_q.addr[21:1])) begin
        if (wr_q.addr[0]) c_word[15:8] <= wr_q.data;
        else              c_word[7:0]  <= wr_q.data;
      end
    end
  end
`else
  assign hit_now  = 1'b0;
  assign hit_byte = '0;
  assign hit_pend = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Interface properties
  // ---------------------------------------------------------------------------
  a_one_strobe: assert property (@(posedge clk) disable iff (reset)
    !(mem_read && mem_write));
  a_ready_idle: assert property (@(posedge clk) disable iff (reset)
    ready |-> (state == IDLE));

endmodule

// File: tb/tb_psram_byte_bridge.sv
module tb_psram_byte_bridge;

  localparam int TO  = 16;
  localparam int LAT = 2;
`ifdef PSRAM_BRIDGE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        timeout_err;
  logic        mem_read;
  logic        mem_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_byte_write;
  logic [15:0] mem_dout = '0;
  logic        mem_busy;

  always #5 clk = ~clk;

  psram_byte_bridge #(.TIMEOUT(TO), .ERR_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .timeout_err(timeout_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_byte_write(mem_byte_write),
    .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  // ---------------- controller model: word memory, LAT-cycle busy ----------
  logic [15:0] mem [int];
  logic        busy_r;
  logic        tb_busy;   // init/config busy driven by the sequence
  bit          hang;      // controller never finishes while set
  int          cnt;
  logic        op_wr;
  logic [21:0] op_a;
  logic [15:0] op_d;

  assign mem_busy = busy_r | tb_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      cnt    <= 0;
    end else if (mem_read || mem_write) begin
      busy_r <= 1'b1;
      cnt    <= LAT;
      op_wr  <= mem_write;
      op_a   <= mem_addr;
      op_d   <= mem_din;
    end else if (busy_r) begin
      if (cnt > 1) cnt <= cnt - 1;
      else if (!hang) begin
        logic [15:0] w;
        int          k;
        busy_r <= 1'b0;
        k = int'(op_a[21:1]);
        w = mem.exists(k) ? mem[k] : 16'h0;
        if (op_wr) begin
          if (op_a[0]) w[15:8] = op_d[15:8];
          else         w[7:0]  = op_d[7:0];
          mem[k] = w;
        end else begin
          mem_dout <= w;
        end
      end
    end
  end

  // ---------------- strobe monitor ----------------
  int          rd_stb = 0, wr_stb = 0, strobe_bad = 0;
  logic [21:0] last_ra = '0, last_wa = '0;
  logic [15:0] last_din = '0;
  logic        last_bw = 1'b0;

  always @(posedge clk) begin
    if (mem_read && mem_write) strobe_bad <= strobe_bad + 1;
    if (mem_read) begin
      rd_stb  <= rd_stb + 1;
      last_ra <= mem_addr;
    end
    if (mem_write) begin
      wr_stb   <= wr_stb + 1;
      last_wa  <= mem_addr;
      last_din <= mem_din;
      last_bw  <= mem_byte_write;
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ready(input string name);
    for (int k = 0; k < 200 && !ready; k++) @(negedge clk);
    chk(name, ready, 1);
  endtask

  task automatic do_read(input logic [21:0] a, output logic [7:0] d,
                         output logic te, output int lat, output int ns);
    int s0;
    bit got;
    wait_ready("rd_ready");
    s0      = rd_stb;
    rd_req  = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_req  = 1'b0;
    lat     = 1;
    got     = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (rd_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("rd_valid_seen", got, 1);
    d  = rd_data;
    te = timeout_err;
    ns = rd_stb - s0;
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] dt,
                          output logic te, output int ns);
    int s0;
    bit got;
    wait_ready("wr_ready");
    s0      = wr_stb;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = dt;
    @(negedge clk);
    wr_req  = 1'b0;
    got     = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (wr_ack) got = 1'b1;
      else @(negedge clk);
    end
    chk("wr_ack_seen", got, 1);
    te = timeout_err;
    ns = wr_stb - s0;
  endtask

  typedef struct {
    logic [21:0] addr;
    logic [15:0] word;   // word preloaded into the model at addr[21:1]
    logic [7:0]  exp;
    bit          same;   // same word as the previous vector (cache hit)
  } rv_t;

  initial begin : main
    rv_t         tbl [7];
    logic [7:0]  d;
    logic        te;
    int          lat, ns, s0, bad, exp_ns;
    int          t_rd, t_rv, t_wr, t_wa;
    logic [7:0]  rd3;
    logic [15:0] din3;
    logic [21:0] wa3;
    logic        bw3;
    bit          rdy_seen;

    tbl[0] = '{22'h000101, 16'hA55A, 8'hA5, 1'b0};
    tbl[1] = '{22'h000100, 16'hA55A, 8'h5A, 1'b1};
    tbl[2] = '{22'h000003, 16'h1234, 8'h12, 1'b0};
    tbl[3] = '{22'h000002, 16'h1234, 8'h34, 1'b1};
    tbl[4] = '{22'h3FFFFF, 16'hC3D2, 8'hC3, 1'b0};
    tbl[5] = '{22'h3FFFFE, 16'hC3D2, 8'hD2, 1'b1};
    tbl[6] = '{22'h000000, 16'h0F1E, 8'h1E, 1'b0};

    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    tb_busy = 1'b1; hang = 1'b0; reset = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_flags", {ready, rd_valid, wr_ack, timeout_err, mem_read, mem_write}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("byte_write_const", mem_byte_write, 1);
    reset = 1'b0;

    // controller init: busy for 100 cycles, requests must be ignored
    bad = 0;
    s0  = rd_stb + wr_stb;
    for (int k = 0; k < 100; k++) begin
      rd_req  = (k < 50);
      rd_addr = 22'h77;
      @(negedge clk);
      if (ready) bad++;
    end
    rd_req = 1'b0;
    chk("init_ready_low", bad, 0);
    chk("init_no_strobe", rd_stb + wr_stb - s0, 0);
    tb_busy = 1'b0;
    @(negedge clk);
    chk("init_ready_up", ready, 1);

    // table of byte reads
    foreach (tbl[i]) begin
      mem[int'(tbl[i].addr[21:1])] = tbl[i].word;
      do_read(tbl[i].addr, d, te, lat, ns);
      exp_ns = (CACHE && tbl[i].same) ? 0 : 1;
      chk($sformatf("vec%0d_data", i), d, tbl[i].exp);
      chk($sformatf("vec%0d_terr", i), te, 0);
      chk($sformatf("vec%0d_strobes", i), ns, exp_ns);
      if (exp_ns == 1) begin
        chk($sformatf("vec%0d_mem_addr", i), last_ra, tbl[i].addr);
        chk($sformatf("vec%0d_lat_ge3", i), lat >= 3, 1);
      end
    end

    // same-cycle read + write: read first, write issues right after rd_valid
    mem[8]  = 16'h7788;
    mem[16] = 16'h1100;
    wait_ready("rw_ready");
    rd_req = 1'b1; rd_addr = 22'h10;
    wr_req = 1'b1; wr_addr = 22'h20; wr_data = 8'h3C;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    t_rd = -1; t_rv = -1; t_wr = -1; t_wa = -1; rdy_seen = 1'b0;
    rd3 = '0; din3 = '0; wa3 = '0; bw3 = 1'b0;
    for (int k = 1; k < 200 && t_wa < 0; k++) begin
      if (ready && !wr_ack) rdy_seen = 1'b1;
      if (mem_read  && t_rd < 0) t_rd = k;
      if (rd_valid  && t_rv < 0) begin t_rv = k; rd3 = rd_data; end
      if (mem_write && t_wr < 0) begin
        t_wr = k; din3 = mem_din; wa3 = mem_addr; bw3 = mem_byte_write;
      end
      if (wr_ack) t_wa = k;
      else @(negedge clk);
    end
    chk("rw_read_first", (t_rd > 0) && (t_rd < t_rv), 1);
    chk("rw_wr_after_rv", t_wr, t_rv + 1);
    chk("rw_ack_after_wr", (t_wr > 0) && (t_wa > t_wr), 1);
    chk("rw_rd_data", rd3, 8'h88);
    chk("rw_mem_din", din3, 16'h3C3C);
    chk("rw_mem_addr", wa3, 22'h20);
    chk("rw_byte_write", bw3, 1);
    chk("rw_ready_held", rdy_seen, 0);
    chk("rw_mem_word", mem[16], 16'h113C);

    // read watchdog
    mem[24] = 16'hAB12;
    hang = 1'b1;
    do_read(22'h30, d, te, lat, ns);
    chk("to_rd_terr", te, 1);
    chk("to_rd_data", d, 8'hFF);
    chk("to_rd_lat", (lat >= TO) && (lat <= TO + 5), 1);
    hang = 1'b0;
    wait_ready("to_ready_again");
    do_read(22'h31, d, te, lat, ns);
    chk("after_to_data", d, 8'hAB);
    chk("after_to_strobes", ns, 1);

    // write watchdog
    hang = 1'b1;
    do_write(22'h60, 8'h12, te, ns);
    chk("to_wr_terr", te, 1);
    chk("to_wr_strobes", ns, 1);
    hang = 1'b0;
    wait_ready("to_wr_ready_again");

    // reset in the middle of WAIT
    hang = 1'b1;
    wait_ready("rst_mid_ready");
    rd_req = 1'b1; rd_addr = 22'h50;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_flags", {ready, rd_valid, wr_ack, timeout_err, mem_read, mem_write}, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hang  = 1'b0;
    bad   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_valid || wr_ack || timeout_err) bad++;
    end
    chk("midrst_no_pulse", bad, 0);
    do_read(22'h000101, d, te, lat, ns);
    chk("postrst_data", d, 8'hA5);
    chk("postrst_strobes", ns, 1);

    // read, write into the same word, read back
    mem[32] = 16'h5566;
    do_read(22'h40, d, te, lat, ns);
    chk("c_rd40", d, 8'h66);
    do_write(22'h41, 8'h77, te, ns);
    chk("c_wr41_terr", te, 0);
    chk("c_wr41_din", last_din, 16'h7777);
    chk("c_wr41_word", mem[32], 16'h7766);
    do_read(22'h41, d, te, lat, ns);
    chk("c_rd41", d, 8'h77);
    chk("c_rd41_strobes", ns, CACHE ? 0 : 1);

    chk("strobe_overlap", strobe_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
